// File: rtl/cpu_pkg.sv
// Shared CPU constants for the fetch front end: opcode/funct/REGIMM codes,
// the PC generator state enum and the default reset vector.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'hBFC0_0000;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT_DS = 2'd2
  } pc_state_e;

  // Sign-extended, word-scaled 16-bit branch displacement.
  function automatic logic [XLEN-1:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/br_resolve.sv
// Combinational control-transfer resolver: decodes the instruction at the
// decode stage, evaluates its condition and forms its target address.
module br_resolve
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  output logic            taken_c,
  output logic [XLEN-1:0] target_c
);

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [4:0]      rt_code;
  logic            rs_neg;
  logic            rs_zero;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;

  assign op      = instr[31:26];
  assign funct   = instr[5:0];
  assign rt_code = instr[20:16];
  assign rs_neg  = rs[XLEN-1];
  assign rs_zero = (rs == '0);
  assign br_tgt  = pc + XLEN'(4) + br_offset(instr[15:0]);
  assign j_tgt   = {pc[31:28], instr[25:0], 2'b00};

  // Signed compares against zero reduce to the sign bit and a zero test.
  always_comb begin
    taken_c  = 1'b0;
    target_c = br_tgt;
    case (op)
      OP_SPECIAL: begin
        if (funct == FN_JR || funct == FN_JALR) begin
          taken_c  = 1'b1;
          target_c = rs;
        end
      end
      OP_REGIMM: begin
        case (rt_code)
          RT_BLTZ, RT_BLTZAL: taken_c = rs_neg;
          RT_BGEZ, RT_BGEZAL: taken_c = ~rs_neg;
          default:            taken_c = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        taken_c  = 1'b1;
        target_c = j_tgt;
      end
      OP_BEQ:  taken_c = (rs == rt);
      OP_BNE:  taken_c = (rs != rt);
      OP_BLEZ: taken_c = rs_neg | rs_zero;
      OP_BGTZ: taken_c = ~rs_neg & ~rs_zero;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with delay-slot handling and exception redirect.
// Optional saturating perf counters are built when PC_GEN_PERF_EN is defined.
module pc_gen
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned PERF_W   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  input  logic        pc_ready_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_instr_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        exp_flush_i,
  input  logic [31:0] exp_pc_i,
  output logic        pc_adel_o
`ifdef PC_GEN_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_taken_o,
  output logic [PERF_W-1:0] perf_flush_o
`endif
);

  if (PERF_W == 0) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  pc_state_e   state_q;
  pc_state_e   state_d;
  logic [31:0] pc_d;
  logic [31:0] tgt_q;
  logic [31:0] tgt_d;
  logic        valid_d;
  logic        taken_c;
  logic [31:0] target_c;
  logic        accept;
  logic        br_hit;
  logic        ds_pending;
  logic        taken_ev;

  br_resolve u_br_resolve (
    .instr    (br_instr_i),
    .pc       (br_pc_i),
    .rs       (rs_data_i),
    .rt       (rt_data_i),
    .taken_c  (taken_c),
    .target_c (target_c)
  );

  assign accept     = pc_valid_o & pc_ready_i;
  assign br_hit     = br_valid_i & taken_c;
  // Delay slot still unfetched: it is on pc_o and is not being accepted now.
  assign ds_pending = (pc_o == br_pc_i + 32'd4) & ~accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (exp_flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     if (br_hit && ds_pending) state_d = WAIT_DS;
        WAIT_DS: if (accept) state_d = RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  // Next PC / latched target; a redirect overrides any branch this cycle.
  always_comb begin
    pc_d     = pc_o;
    tgt_d    = tgt_q;
    taken_ev = 1'b0;
    if (exp_flush_i) begin
      pc_d  = exp_pc_i;
      tgt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (br_hit) begin
            taken_ev = 1'b1;
            if (ds_pending) tgt_d = target_c;
            else            pc_d  = target_c;
          end else if (accept) begin
            pc_d = pc_o + 32'd4;
          end
        end
        WAIT_DS: begin
          if (accept) begin
            pc_d  = tgt_q;
            tgt_d = '0;
          end
        end
        default: ;
      endcase
    end
    valid_d = (state_d != BOOT);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_o       <= RESET_PC;
      pc_valid_o <= 1'b0;
      tgt_q      <= '0;
    end else begin
      pc_o       <= pc_d;
      pc_valid_o <= valid_d;
      tgt_q      <= tgt_d;
    end
  end

  assign pc_adel_o = |pc_o[1:0];

`ifdef PC_GEN_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_taken_o <= '0;
      perf_flush_o <= '0;
    end else begin
      if (taken_ev && !(&perf_taken_o))    perf_taken_o <= perf_taken_o + PERF_W'(1);
      if (exp_flush_i && !(&perf_flush_o)) perf_flush_o <= perf_flush_o + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vectors, corner sequences and a
// randomized run against a behavioural model. Perf checks need PC_GEN_PERF_EN.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        br_valid;
  logic [31:0] br_instr;
  logic [31:0] br_pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exp_flush;
  logic [31:0] exp_pc;
  logic        pc_adel;
`ifdef PC_GEN_PERF_EN
  logic [3:0]  perf_taken;
  logic [3:0]  perf_flush;
`endif

  pc_gen #(.RESET_PC(RST_PC), .PERF_W(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .pc_o        (pc),
    .pc_valid_o  (pc_valid),
    .pc_ready_i  (pc_ready),
    .br_valid_i  (br_valid),
    .br_instr_i  (br_instr),
    .br_pc_i     (br_pc),
    .rs_data_i   (rs_data),
    .rt_data_i   (rt_data),
    .exp_flush_i (exp_flush),
    .exp_pc_i    (exp_pc),
    .pc_adel_o   (pc_adel)
`ifdef PC_GEN_PERF_EN
    ,
    .perf_taken_o(perf_taken),
    .perf_flush_o(perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] bpc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        taken;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] target);
    pc_ready  = 1'b0;
    br_valid  = 1'b0;
    exp_flush = 1'b1;
    exp_pc    = target;
    cycle();
    exp_flush = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    cycle();
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] bpc,
                         input logic [31:0] a, input logic [31:0] b);
    br_valid = 1'b1;
    br_instr = ins;
    br_pc    = bpc;
    rs_data  = a;
    rt_data  = b;
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {op, 5'd1, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [5:0] funct);
    return {6'd0, 5'd3, 15'd0, funct};
  endfunction

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  // Reference resolver: operands as signed integers, target by plain arithmetic.
  function automatic logic ref_taken(input logic [31:0] ins, input logic [31:0] bpc,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] t);
    int sa;
    int sb;
    int off;
    logic res;
    sa  = a;
    sb  = b;
    off = int'($signed(ins[15:0]));
    t   = bpc + 32'd4 + 32'(off * 4);
    res = 1'b0;
    case (int'(ins[31:26]))
      0: if (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) begin res = 1'b1; t = a; end
      1: begin
        if (ins[20:16] == 5'd0 || ins[20:16] == 5'd16) res = (sa < 0);
        else if (ins[20:16] == 5'd1 || ins[20:16] == 5'd17) res = (sa >= 0);
      end
      2, 3: begin res = 1'b1; t = {bpc[31:28], ins[25:0], 2'b00}; end
      4: res = (sa == sb);
      5: res = (sa != sb);
      6: res = (sa <= 0);
      7: res = (sa > 0);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] code;
    case ($urandom_range(0, 3))
      0: code = 5'd0;
      1: code = 5'd1;
      2: code = 5'd16;
      default: code = 5'd17;
    endcase
    if ($urandom_range(0, 5) == 0) code = 5'd2;
    case ($urandom_range(0, 7))
      0: return {6'($urandom_range(2, 3)), 26'($urandom)};
      1: return {6'd0, 5'($urandom), 15'd0, 6'($urandom_range(8, 9))};
      2: return {6'($urandom_range(4, 7)), 10'($urandom), 16'($urandom)};
      3: return {6'd1, 5'($urandom), code, 16'($urandom)};
      4: return {6'($urandom_range(8, 63)), 26'($urandom)};
      5: return {6'd0, 20'($urandom), 6'h20};
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  logic        m_pend;

  initial begin
    resetn    = 1'b0;
    pc_ready  = 1'b0;
    br_valid  = 1'b0;
    br_instr  = '0;
    br_pc     = '0;
    rs_data   = '0;
    rt_data   = '0;
    exp_flush = 1'b0;
    exp_pc    = '0;

    vecs.push_back('{mk_i(6'd4, 5'd2, 16'h0010), 32'h0000_1000, 32'd7, 32'd7, 1'b1, 32'h0000_1044});
    vecs.push_back('{mk_i(6'd4, 5'd2, 16'h0010), 32'h0000_1000, 32'd1, 32'd2, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd5, 5'd2, 16'hFFFE), 32'h0000_2000, 32'd1, 32'd2, 1'b1, 32'h0000_1FFC});
    vecs.push_back('{mk_i(6'd5, 5'd2, 16'h0004), 32'h0000_2000, 32'd3, 32'd3, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd6, 5'd0, 16'h0001), 32'h0000_3000, 32'd0, 32'd9, 1'b1, 32'h0000_3008});
    vecs.push_back('{mk_i(6'd6, 5'd0, 16'h0001), 32'h0000_3000, 32'd1, 32'd0, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd7, 5'd0, 16'h0002), 32'h0000_4000, 32'd0, 32'd0, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd7, 5'd0, 16'h0002), 32'h0000_4000, 32'd1, 32'd0, 1'b1, 32'h0000_400C});
    vecs.push_back('{mk_i(6'd1, 5'd0, 16'h0003), 32'h0000_5000, 32'h8000_0000, 32'd0, 1'b1, 32'h0000_5010});
    vecs.push_back('{mk_i(6'd1, 5'd0, 16'h0003), 32'h0000_5000, 32'd0, 32'd0, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd1, 5'd1, 16'h0000), 32'h0000_6000, 32'd0, 32'd0, 1'b1, 32'h0000_6004});
    vecs.push_back('{mk_i(6'd1, 5'd17, 16'h0000), 32'h0000_6000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd1, 5'd16, 16'h8000), 32'h0000_7000, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFE_7004});
    vecs.push_back('{mk_i(6'd1, 5'd2, 16'h0004), 32'h0000_7000, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'h0});
    vecs.push_back('{mk_j(6'd2, 26'h000_0040), 32'hA000_0000, 32'd0, 32'd0, 1'b1, 32'hA000_0100});
    vecs.push_back('{mk_j(6'd3, 26'h3FF_FFFF), 32'h3000_0010, 32'd0, 32'd0, 1'b1, 32'h3FFF_FFFC});
    vecs.push_back('{mk_r(6'h20), 32'h0000_8000, 32'd5, 32'd5, 1'b0, 32'h0});
    vecs.push_back('{mk_i(6'd4, 5'd2, 16'h0000), 32'hFFFF_FFFC, 32'd4, 32'd4, 1'b1, 32'h0000_0000});
    vecs.push_back('{mk_r(6'h09), 32'h0000_0300, 32'h0000_1002, 32'd0, 1'b1, 32'h0000_1002});

    // Reset state and boot sequence.
    cycle();
    cycle();
    check("rst_pc", pc, RST_PC);
    check("rst_valid", 32'(pc_valid), 32'd0);
    pc_ready = 1'b1;
    resetn   = 1'b1;
    #1;
    check("boot_valid", 32'(pc_valid), 32'd0);
    cycle();
    check("boot_pc0", pc, 32'hBFC0_0000);
    check("boot_valid1", 32'(pc_valid), 32'd1);
    cycle();
    check("boot_pc1", pc, 32'hBFC0_0004);
    cycle();
    check("boot_pc2", pc, 32'hBFC0_0008);

    // Directed decode vectors: delay slot already accepted, fetch stalled.
    foreach (vecs[i]) begin
      flush_to(vecs[i].bpc + 32'd8);
      present(vecs[i].instr, vecs[i].bpc, vecs[i].rs, vecs[i].rt);
      cycle();
      br_valid = 1'b0;
      check($sformatf("vec%0d_pc", i), pc,
            vecs[i].taken ? vecs[i].tgt : vecs[i].bpc + 32'd8);
    end

    // beq with delay slot pending and a stalled fetch; a branch in WAIT_DS is ignored.
    flush_to(32'h0000_0104);
    present(mk_i(6'd4, 5'd2, 16'h0010), 32'h0000_0100, 32'd5, 32'd5);
    cycle();
    check("ds_hold0", pc, 32'h0000_0104);
    present(mk_r(6'h08), 32'h0000_0200, 32'h0000_9000, 32'd0);
    cycle();
    br_valid = 1'b0;
    check("ds_hold1", pc, 32'h0000_0104);
    cycle();
    check("ds_hold2", pc, 32'h0000_0104);
    pc_ready = 1'b1;
    cycle();
    check("ds_target", pc, 32'h0000_0144);
    cycle();
    check("ds_after", pc, 32'h0000_0148);

    // jr after its delay slot was accepted: redirect immediately, remain in RUN.
    flush_to(32'h0000_0108);
    pc_ready = 1'b1;
    present(mk_r(6'h08), 32'h0000_0100, 32'h8000_0200, 32'd0);
    cycle();
    br_valid = 1'b0;
    check("jr_pc", pc, 32'h8000_0200);
    cycle();
    check("jr_run", pc, 32'h8000_0204);

    // Exception flush coincident with a taken bne.
    flush_to(32'h0000_0204);
    pc_ready = 1'b1;
    present(mk_i(6'd5, 5'd2, 16'h0040), 32'h0000_0200, 32'd1, 32'd2);
    exp_flush = 1'b1;
    exp_pc    = 32'hBFC0_0380;
    cycle();
    br_valid  = 1'b0;
    exp_flush = 1'b0;
    check("flush_br_pc", pc, 32'hBFC0_0380);
    cycle();
    check("flush_br_next", pc, 32'hBFC0_0384);

    // Exception flush during WAIT_DS discards the latched target.
    flush_to(32'h0000_0204);
    present(mk_i(6'd5, 5'd2, 16'h0040), 32'h0000_0200, 32'd1, 32'd2);
    cycle();
    br_valid = 1'b0;
    check("flush_ds_hold", pc, 32'h0000_0204);
    exp_flush = 1'b1;
    exp_pc    = 32'hBFC0_0380;
    cycle();
    exp_flush = 1'b0;
    check("flush_ds_pc", pc, 32'hBFC0_0380);
    pc_ready = 1'b1;
    cycle();
    check("flush_ds_next", pc, 32'hBFC0_0384);

    // Misaligned jalr target is presented and flagged.
    flush_to(32'h0000_0308);
    check("adel_clear", 32'(pc_adel), 32'd0);
    present(mk_r(6'h09), 32'h0000_0300, 32'h0000_1002, 32'd0);
    cycle();
    br_valid = 1'b0;
    check("jalr_pc", pc, 32'h0000_1002);
    check("jalr_adel", 32'(pc_adel), 32'd1);

`ifdef PC_GEN_PERF_EN
    // Saturating perf counters.
    do_reset();
    check("perf_taken_rst", 32'(perf_taken), 32'd0);
    check("perf_flush_rst", 32'(perf_flush), 32'd0);
    flush_to(32'h0000_0100);
    pc_ready = 1'b1;
    present(mk_r(6'h08), 32'h0001_0000, 32'h0000_0100, 32'd0);
    repeat (20) cycle();
    br_valid = 1'b0;
    check("perf_taken_sat", 32'(perf_taken), 32'd15);
    check("perf_flush_cnt", 32'(perf_flush), 32'd1);
    check("perf_pc", pc, 32'h0000_0100);
`endif

    // Reset arriving mid-WAIT_DS.
    flush_to(32'h0000_0104);
    present(mk_i(6'd4, 5'd2, 16'h0010), 32'h0000_0100, 32'd5, 32'd5);
    cycle();
    br_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    check("rst_ds_pc", pc, RST_PC);
    check("rst_ds_valid", 32'(pc_valid), 32'd0);
`ifdef PC_GEN_PERF_EN
    check("rst_ds_taken", 32'(perf_taken), 32'd0);
    check("rst_ds_flush", 32'(perf_flush), 32'd0);
`endif
    #2;
    resetn   = 1'b1;
    pc_ready = 1'b1;
    cycle();
    check("rst_ds_boot", pc, RST_PC);
    cycle();
    check("rst_ds_next", pc, RST_PC + 32'd4);

    // Randomized run against the behavioural model.
    flush_to(32'h0000_4000);
    m_pc   = 32'h0000_4000;
    m_pend = 1'b0;
    m_tgt  = '0;
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] t;
      logic        tk;
      pc_ready  = ($urandom_range(0, 3) != 0);
      exp_flush = ($urandom_range(0, 19) == 0);
      exp_pc    = $urandom & 32'hFFFF_FFFC;
      br_valid  = ($urandom_range(0, 2) == 0);
      br_pc     = ($urandom_range(0, 1) == 1) ? m_pc - 32'd4 : ($urandom & 32'hFFFF_FFFC);
      br_instr  = rnd_instr();
      rs_data   = rnd_operand();
      rt_data   = rnd_operand();
      tk = ref_taken(br_instr, br_pc, rs_data, rt_data, t);
      if (exp_flush) begin
        m_pc   = exp_pc;
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (pc_ready) begin
          m_pc   = m_tgt;
          m_pend = 1'b0;
        end
      end else if (br_valid && tk) begin
        if (m_pc == br_pc + 32'd4 && !pc_ready) begin
          m_pend = 1'b1;
          m_tgt  = t;
        end else begin
          m_pc = t;
        end
      end else if (pc_ready) begin
        m_pc = m_pc + 32'd4;
      end
      cycle();
      check($sformatf("rnd%0d_pc", n), pc, m_pc);
      check($sformatf("rnd%0d_valid", n), 32'(pc_valid), 32'd1);
      check($sformatf("rnd%0d_adel", n), 32'(pc_adel), 32'(|m_pc[1:0]));
    end
    br_valid  = 1'b0;
    exp_flush = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
